// File: rtl/wb_intercon_n.sv
// wb_intercon_n: one-master Wishbone interconnect with priority decode, decode-miss error and ack timeout
module wb_intercon_n #(
    parameter int data_width = 32,
    parameter int adr_width = 32,
    parameter int sel_width = 2,
    parameter int num_slaves = 7,
    parameter logic [num_slaves*adr_width-1:0] slave_masks = '0,
    parameter logic [num_slaves*adr_width-1:0] slave_addrs = '0,
    parameter int timeout_cycles = 255
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    input  logic [adr_width-1:0]             wbm_adr_i,
    input  logic [data_width-1:0]            wbm_dat_i,
    input  logic [sel_width-1:0]             wbm_sel_i,
    input  logic                             wbm_we_i,
    input  logic                             wbm_cyc_i,
    input  logic                             wbm_stb_i,
    output logic [data_width-1:0]            wbm_dat_o,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic [num_slaves*adr_width-1:0]  wbs_adr_o,
    output logic [num_slaves*data_width-1:0] wbs_dat_o,
    output logic [num_slaves*sel_width-1:0]  wbs_sel_o,
    output logic [num_slaves-1:0]            wbs_we_o,
    output logic [num_slaves-1:0]            wbs_cyc_o,
    output logic [num_slaves-1:0]            wbs_stb_o,
    input  logic [num_slaves*data_width-1:0] wbs_dat_i,
    input  logic [num_slaves-1:0]            wbs_ack_i,
    output logic                             err_cause_o,
    output logic [adr_width-1:0]             err_adr_o
);
    // a zero timeout still needs a legal one-bit counter
    localparam int cw = timeout_cycles > 0 ? $clog2(timeout_cycles + 1) : 1;

    typedef enum logic [1:0] {idle, active, err} state_t;

    state_t state, state_nxt;
    logic [num_slaves-1:0] grant, grant_nxt, hit, hit_oh;
    logic [cw-1:0] cnt, cnt_nxt;
    logic [data_width-1:0] dat_sel;
    logic req, any_hit, gack, tmo, cap, cause_nxt;

    assign req = wbm_cyc_i & wbm_stb_i;

    assign wbs_adr_o = {num_slaves{wbm_adr_i}};
    assign wbs_dat_o = {num_slaves{wbm_dat_i}};
    assign wbs_sel_o = {num_slaves{wbm_sel_i}};
    assign wbs_we_o  = {num_slaves{wbm_we_i}};
    assign wbs_cyc_o = {num_slaves{wbm_cyc_i}};

    genvar i;
    generate
        for (i = 0; i < num_slaves; i++) begin : g_dec
            assign hit[i] = (wbm_adr_i & slave_masks[i*adr_width +: adr_width]) == slave_addrs[i*adr_width +: adr_width];
        end
    endgenerate

    // lowest-index hit wins so overlapping windows resolve deterministically
    always_comb begin
        hit_oh = '0;
        any_hit = 1'b0;
        for (int k = 0; k < num_slaves; k++) begin
            if (hit[k] && !any_hit) begin
                hit_oh[k] = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

    // return path from the granted slave only
    always_comb begin
        dat_sel = '0;
        for (int k = 0; k < num_slaves; k++)
            dat_sel = dat_sel | (grant[k] ? wbs_dat_i[k*data_width +: data_width] : '0);
        gack = |(grant & wbs_ack_i);
    end

    // an ack arriving in the timeout cycle takes precedence over the error
    assign tmo = (timeout_cycles != 0) && (cnt == cw'(timeout_cycles)) && !gack;

    assign wbs_stb_o = (state == active && req) ? grant : '0;
    assign wbm_ack_o = state == active && wbm_cyc_i && gack;
    assign wbm_err_o = state == err || (state == active && wbm_cyc_i && tmo);
    assign wbm_dat_o = state == active ? dat_sel : '0;

    // transfer sequencing: decode, wait for ack, abort or error out
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt = cnt;
        cap = 1'b0;
        cause_nxt = err_cause_o;
        case (state)
            idle: begin
                if (req && any_hit) begin
                    grant_nxt = hit_oh;
                    cnt_nxt = '0;
                    state_nxt = active;
                end else if (req) begin
                    cap = 1'b1;
                    cause_nxt = 1'b0;
                    state_nxt = err;
                end
            end
            active: begin
                if (!wbm_cyc_i || gack) begin
                    state_nxt = idle;
                end else if (tmo) begin
                    cap = 1'b1;
                    cause_nxt = 1'b1;
                    state_nxt = idle;
                end else begin
                    cnt_nxt = (cnt == {cw{1'b1}}) ? cnt : cnt + cw'(1);
                end
            end
            default: state_nxt = idle;
        endcase
    end

    // state, grant, counter and error capture registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= idle;
            grant <= '0;
            cnt <= '0;
            err_cause_o <= 1'b0;
            err_adr_o <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            cnt <= cnt_nxt;
            err_cause_o <= cause_nxt;
            if (cap)
                err_adr_o <= wbm_adr_i;
        end
    end
endmodule

// File: tb/tb_wb_intercon_n.sv
// tb_wb_intercon_n: directed checks of decode, priority, errors, timeout, abort and reset
module tb_wb_intercon_n;
    localparam int ns = 7;
    localparam logic [ns*32-1:0] masks = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FF00, 32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_FFFF};
    localparam logic [ns*32-1:0] addrs = {32'h4000_0006, 32'h4000_0005, 32'h4000_0004,
        32'h0000_1000, 32'hF000_0000, 32'h0000_1000, 32'h0000_0004};

    logic clk = 0, rst_n = 0;
    logic [31:0] m_adr = 0, m_dat = 0, s_dat_o;
    logic [1:0] m_sel = 0;
    logic m_we = 0, m_cyc = 0, m_stb = 0, ack, err, cause;
    logic [ns*32-1:0] s_adr, s_dat, s_dat_i;
    logic [ns*2-1:0] s_sel;
    logic [ns-1:0] s_we, s_cyc, s_stb, s_ack, ack_en = 0;
    logic [31:0] e_adr;
    int errors = 0, checks = 0;

    wb_intercon_n #(.num_slaves(ns), .slave_masks(masks), .slave_addrs(addrs), .timeout_cycles(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
        .wbm_dat_o(s_dat_o), .wbm_ack_o(ack), .wbm_err_o(err),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack),
        .err_cause_o(cause), .err_adr_o(e_adr)
    );

    always #5 clk = ~clk;

    assign s_ack = s_stb & ack_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a);
        m_adr = a;
        m_cyc = 1;
        m_stb = 1;
    endtask

    task automatic drop();
        m_cyc = 0;
        m_stb = 0;
    endtask

    initial begin
        for (int i = 0; i < ns; i++)
            s_dat_i[i*32 +: 32] = (i == 2) ? 32'hDEAD_BEEF : 32'h1111_1111 * i;
        m_cyc = 1;
        #12;
        chk("rst_stb", s_stb, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_dat", s_dat_o, 0);
        chk("rst_cause", cause, 0);
        chk("rst_eadr", e_adr, 0);
        chk("rst_cyc", s_cyc, 7'h7F);
        m_cyc = 0;
        nxt();
        rst_n = 1;
        nxt();
        chk("cyc_idle", s_cyc, 0);

        // zero-wait read from slave 2
        ack_en = 7'b0000100;
        req(32'hF000_0010);
        @(negedge clk);
        chk("rd_c0_stb", s_stb, 0);
        chk("rd_c0_ack", ack, 0);
        nxt();
        @(negedge clk);
        chk("rd_c1_stb", s_stb, 7'b0000100);
        chk("rd_c1_ack", ack, 1);
        chk("rd_c1_dat", s_dat_o, 32'hDEAD_BEEF);
        chk("rd_c1_err", err, 0);
        chk("rd_bcast_adr", s_adr[5*32 +: 32], 32'hF000_0010);
        nxt();
        drop();
        @(negedge clk);
        chk("rd_c2_stb", s_stb, 0);
        chk("rd_c2_dat", s_dat_o, 0);
        nxt();

        // overlap: slave 1 wins over slave 3
        ack_en = 7'b0001000;
        req(32'h0000_1000);
        nxt();
        @(negedge clk);
        chk("ov_stb", s_stb, 7'b0000010);
        chk("ov_ack3", ack, 0);
        nxt();
        ack_en = 7'b0001010;
        @(negedge clk);
        chk("ov_ack1", ack, 1);
        chk("ov_dat", s_dat_o, 32'h1111_1111);
        nxt();
        drop();
        nxt();

        // decode miss
        req(32'h8000_0000);
        @(negedge clk);
        chk("miss_c0_err", err, 0);
        nxt();
        drop();
        @(negedge clk);
        chk("miss_c1_err", err, 1);
        chk("miss_c1_ack", ack, 0);
        chk("miss_cause", cause, 0);
        chk("miss_eadr", e_adr, 32'h8000_0000);
        nxt();
        @(negedge clk);
        chk("miss_c2_err", err, 0);
        nxt();

        // timeout after 4 waiting cycles
        ack_en = 0;
        req(32'hF000_0020);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            @(negedge clk);
            chk("to_wait_err", err, 0);
            chk("to_wait_stb", s_stb, 7'b0000100);
        end
        nxt();
        @(negedge clk);
        chk("to_c5_err", err, 1);
        chk("to_c5_ack", ack, 0);
        nxt();
        drop();
        @(negedge clk);
        chk("to_c6_stb", s_stb, 0);
        chk("to_c6_err", err, 0);
        chk("to_cause", cause, 1);
        chk("to_eadr", e_adr, 32'hF000_0020);
        nxt();

        // ack in the timeout cycle wins
        req(32'hF000_0030);
        repeat (5) nxt();
        ack_en = 7'b0000100;
        @(negedge clk);
        chk("tw_ack", ack, 1);
        chk("tw_err", err, 0);
        nxt();
        drop();
        @(negedge clk);
        chk("tw_eadr", e_adr, 32'hF000_0020);
        nxt();

        // master abort mid-wait
        ack_en = 0;
        req(32'hF000_0040);
        nxt();
        @(negedge clk);
        chk("ab_c1_stb", s_stb, 7'b0000100);
        nxt();
        m_cyc = 0;
        @(negedge clk);
        chk("ab_c2_stb", s_stb, 0);
        chk("ab_c2_ack", ack, 0);
        chk("ab_c2_err", err, 0);
        nxt();
        m_stb = 0;
        repeat (4) begin
            @(negedge clk);
            chk("ab_idle_err", err, 0);
            nxt();
        end
        ack_en = 7'b0000100;
        req(32'hF000_0050);
        nxt();
        @(negedge clk);
        chk("ab_next_ack", ack, 1);
        chk("ab_next_dat", s_dat_o, 32'hDEAD_BEEF);
        nxt();
        drop();
        nxt();

        // asynchronous reset mid-transfer
        ack_en = 0;
        req(32'hF000_0060);
        nxt();
        @(negedge clk);
        chk("rs_pre_stb", s_stb, 7'b0000100);
        #2;
        rst_n = 0;
        #1;
        chk("rs_stb", s_stb, 0);
        chk("rs_ack", ack, 0);
        chk("rs_err", err, 0);
        drop();
        nxt();
        rst_n = 1;
        @(negedge clk);
        chk("rs_eadr", e_adr, 0);
        chk("rs_cause", cause, 0);
        chk("rs_idle_stb", s_stb, 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
